branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor with a branch target buffer (BTB) for the 5-stage pipelined CPU. In IF it predicts the next PC from the fetch PC, replacing the fixed PC+4 choice and the EX-stage flush of every taken branch. In EX it is trained with each resolved branch and flags mispredictions. It also keeps a saturating misprediction counter for performance runs.

## Interface
- ENTRIES, 16, BTB entries; power of 2, ≥ 2
- CTR_BITS, 2, width of each saturating direction counter; 1..4
- PC_WIDTH, 32, PC width
- CNT_WIDTH, 16, width of the misprediction statistics counter
- Index field: IDX = log2(ENTRIES). Tag field: TAG = PC_WIDTH − IDX − 2.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- FetchPc  in  PC_WIDTH  IF-stage PC
- PredTaken  out  1  prediction for FetchPc, combinational
- PredNextPc  out  PC_WIDTH  predicted next PC, combinational
- UpdateValid  in  1  a resolved branch is in EX this cycle
- UpdatePc  in  PC_WIDTH  PC of the resolved branch
- UpdateTaken  in  1  actual branch outcome
- UpdateTarget  in  PC_WIDTH  actual branch target
- UpdatePredTaken  in  1  prediction made for this branch, carried down the pipeline
- UpdatePredNextPc  in  PC_WIDTH  predicted next PC, carried down the pipeline
- Mispredict  out  1  combinational; high when the EX redirect must flush IF/ID
- Flush  in  1  synchronous invalidate of all BTB entries
- MispredictCount  out  CNT_WIDTH  registered saturating count of mispredictions

## Operation
- Entry fields: valid, tag[TAG], ctr[CTR_BITS], target[PC_WIDTH].
- Addressing: index = PC[IDX+1:2], tag = PC[PC_WIDTH−1:IDX+2]. PC[1:0] is ignored.
- Lookup:
  - hit = valid[index] && tag match
  - PredTaken = hit && ctr[CTR_BITS−1]
  - PredNextPc = target when PredTaken, else FetchPc + 4 (modulo 2^PC_WIDTH)
- Actual next PC: act = UpdateTaken ? UpdateTarget : UpdatePc + 4.
- Mispredict = UpdateValid && (UpdatePredNextPc != act). This covers a wrong direction and a wrong target.
- Update on an UpdateValid cycle:
  - On a hit: ctr increments on taken, decrements on not-taken, and saturates at 2^CTR_BITS−1 and 0.
  - On a hit and taken: target is rewritten with UpdateTarget.
  - On a miss and taken: allocate the entry, overwriting any previous occupant. Set valid = 1, the new tag, ctr = 2^(CTR_BITS−1) (weakly taken), target = UpdateTarget.
  - On a miss and not-taken: no change to the entry.
- MispredictCount increments on each Mispredict cycle and saturates at all-ones.
- Flush clears every valid bit at the next edge. Counters, targets and MispredictCount are kept.
- Flush and UpdateValid in the same cycle: Flush wins, and no entry is written. MispredictCount still counts the mispredict.

## Timing
- Lookup has zero latency (combinational from FetchPc).
- An update becomes visible to lookups from the cycle after the update edge.
- Lookup and update on the same index in the same cycle: the lookup sees the pre-update state.
- Reset values while reset is asserted:
  - all valid = 0, ctr = 0, target = 0, MispredictCount = 0
  - outputs: PredTaken = 0, PredNextPc = FetchPc + 4
  - Mispredict stays purely combinational from its inputs.
- Reset asserted mid-operation takes effect immediately, asynchronously. The first update accepted is the one at the first rising edge after reset deasserts.
- There is no handshake. The pipeline must hold the Update* inputs stable for the cycle in which UpdateValid is high.

## Structure
- cpu_pkg holds:
  - PC_WIDTH default
  - PC increment constant (4)
  - function sat_inc_dec(ctr, up) used by any counter-based predictor
- sat_counter: one sub-module, parametrised by width. Used both for the per-entry direction counter update logic and for MispredictCount.
- BTB arrays are flop-based regfiles, so the asynchronous reset of every entry is legal. No memory macro is used.

## Test plan
- Reset, then FetchPc = 0x40 -> PredTaken = 0, PredNextPc = 0x44, MispredictCount = 0.
- Update with UpdatePc = 0x40, taken, target 0x80, UpdatePredNextPc = 0x44 -> Mispredict = 1 that cycle. Next cycle, FetchPc = 0x40 gives PredTaken = 1, PredNextPc = 0x80, MispredictCount = 1.
- Counter training, CTR_BITS = 2, on 0x40:
  - Two not-taken updates -> ctr goes 2, 1, 0, then PredNextPc = 0x44.
  - A further not-taken keeps ctr at 0.
  - Four taken updates -> ctr saturates at 3.
- Alias eviction, ENTRIES = 16:
  - 0x40 is taken and allocated. Then 0x80 (same index, different tag) is resolved taken, target 0x200.
  - Lookup of 0x40 then misses (PC+4). Lookup of 0x80 predicts 0x200.
- Same-cycle lookup and update of 0x40 -> the lookup returns the old prediction and the next cycle shows the new one.
- Boundary events:
  - Flush with a simultaneous taken update -> all lookups miss next cycle.
  - Force 2^CNT_WIDTH + 3 mispredicts -> MispredictCount holds all-ones.
  - Assert reset mid-stream -> all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and helpers used by the branch predictor and its counters.
package cpu_pkg;

  localparam int unsigned PC_WIDTH_DEFAULT = 32;
  localparam int unsigned PC_INCREMENT     = 4;

  // Widest counter the shared step function supports.
  localparam int unsigned SAT_MAX_WIDTH = 32;

  typedef logic [SAT_MAX_WIDTH-1:0] satWord_t;

  // One saturating step towards maxVal (up) or towards zero (down).
  function automatic satWord_t sat_inc_dec(input satWord_t ctr, input logic up,
                                           input satWord_t maxVal);
    satWord_t res;
    if (up) begin
      res = (ctr >= maxVal) ? maxVal : ctr + satWord_t'(1);
    end else begin
      res = (ctr == '0) ? '0 : ctr - satWord_t'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for a saturating up/down counter of WIDTH bits (WIDTH <= 32).
module sat_counter
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] value,
  input  logic             enable,
  input  logic             countUp,
  output logic [WIDTH-1:0] nextValue
);

  localparam satWord_t MaxVal = satWord_t'({WIDTH{1'b1}});

  satWord_t stepped;

  always_comb begin
    stepped   = sat_inc_dec(satWord_t'(value), countUp, MaxVal);
    nextValue = enable ? stepped[WIDTH-1:0] : value;
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters, trained from EX,
// plus a saturating misprediction counter.
module branch_predictor
  import cpu_pkg::*;
#(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned PC_WIDTH  = PC_WIDTH_DEFAULT,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  FetchPc,
  output logic                 PredTaken,
  output logic [PC_WIDTH-1:0]  PredNextPc,
  input  logic                 UpdateValid,
  input  logic [PC_WIDTH-1:0]  UpdatePc,
  input  logic                 UpdateTaken,
  input  logic [PC_WIDTH-1:0]  UpdateTarget,
  input  logic                 UpdatePredTaken,
  input  logic [PC_WIDTH-1:0]  UpdatePredNextPc,
  output logic                 Mispredict,
  input  logic                 Flush,
  output logic [CNT_WIDTH-1:0] MispredictCount
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam int unsigned TAG = PC_WIDTH - IDX - 2;

  localparam logic [CTR_BITS-1:0] WeakTaken = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [PC_WIDTH-1:0] PcStep    = PC_WIDTH'(PC_INCREMENT);

  logic                validQ  [ENTRIES];
  logic [TAG-1:0]      tagQ    [ENTRIES];
  logic [CTR_BITS-1:0] ctrQ    [ENTRIES];
  logic [PC_WIDTH-1:0] targetQ [ENTRIES];

  logic [CNT_WIDTH-1:0] mispredictCountQ, mispredictCountD;

  logic [IDX-1:0]      fetchIdx, updIdx;
  logic [TAG-1:0]      fetchTag, updTag;
  logic                fetchHit, updHit;
  logic [PC_WIDTH-1:0] actNextPc;
  logic [CTR_BITS-1:0] ctrNext;

  assign fetchIdx = FetchPc[IDX+1:2];
  assign fetchTag = FetchPc[PC_WIDTH-1:IDX+2];
  assign updIdx   = UpdatePc[IDX+1:2];
  assign updTag   = UpdatePc[PC_WIDTH-1:IDX+2];

  // Lookup reads the registered arrays, so a same-cycle update is not yet visible.
  always_comb begin
    fetchHit   = validQ[fetchIdx] && (tagQ[fetchIdx] == fetchTag);
    PredTaken  = fetchHit && ctrQ[fetchIdx][CTR_BITS-1];
    PredNextPc = PredTaken ? targetQ[fetchIdx] : FetchPc + PcStep;
  end

  // Comparing full next PCs catches both wrong direction and wrong target.
  always_comb begin
    updHit     = validQ[updIdx] && (tagQ[updIdx] == updTag);
    actNextPc  = UpdateTaken ? UpdateTarget : UpdatePc + PcStep;
    Mispredict = UpdateValid && (UpdatePredNextPc != actNextPc);
  end

  sat_counter #(
    .WIDTH(CTR_BITS)
  ) dirCtrStep (
    .value    (ctrQ[updIdx]),
    .enable   (1'b1),
    .countUp  (UpdateTaken),
    .nextValue(ctrNext)
  );

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) missCtrStep (
    .value    (mispredictCountQ),
    .enable   (Mispredict),
    .countUp  (1'b1),
    .nextValue(mispredictCountD)
  );

  assign MispredictCount = mispredictCountQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        validQ[i]  <= 1'b0;
        tagQ[i]    <= '0;
        ctrQ[i]    <= '0;
        targetQ[i] <= '0;
      end
      mispredictCountQ <= '0;
    end else begin
      mispredictCountQ <= mispredictCountD;
      if (Flush) begin
        // Flush beats a concurrent update; only the valid bits are dropped.
        for (int unsigned i = 0; i < ENTRIES; i++) begin
          validQ[i] <= 1'b0;
        end
      end else if (UpdateValid) begin
        if (updHit) begin
          ctrQ[updIdx] <= ctrNext;
          if (UpdateTaken) begin
            targetQ[updIdx] <= UpdateTarget;
          end
        end else if (UpdateTaken) begin
          validQ[updIdx]  <= 1'b1;
          tagQ[updIdx]    <= updTag;
          ctrQ[updIdx]    <= WeakTaken;
          targetQ[updIdx] <= UpdateTarget;
        end
      end
    end
  end

  // A branch carried down as predicted not-taken must have been predicted to fall through.
  assert property (@(posedge clk) disable iff (reset)
    (UpdateValid && !UpdatePredTaken) |-> (UpdatePredNextPc == UpdatePc + PcStep));

endmodule

// File: tb/tb_branch_predictor.sv
// Randomised and directed bench for branch_predictor against an array-based BTB model.
module tb_branch_predictor;

  localparam int unsigned ENTRIES   = 16;
  localparam int unsigned CTR_BITS  = 2;
  localparam int unsigned PC_WIDTH  = 32;
  localparam int unsigned CNT_WIDTH = 8;
  localparam int CtrMax  = 3;
  localparam int CtrHalf = 2;
  localparam int CntMax  = 255;

  logic                 clk;
  logic                 reset;
  logic [PC_WIDTH-1:0]  FetchPc;
  logic                 PredTaken;
  logic [PC_WIDTH-1:0]  PredNextPc;
  logic                 UpdateValid;
  logic [PC_WIDTH-1:0]  UpdatePc;
  logic                 UpdateTaken;
  logic [PC_WIDTH-1:0]  UpdateTarget;
  logic                 UpdatePredTaken;
  logic [PC_WIDTH-1:0]  UpdatePredNextPc;
  logic                 Mispredict;
  logic                 Flush;
  logic [CNT_WIDTH-1:0] MispredictCount;

  branch_predictor #(
    .ENTRIES  (ENTRIES),
    .CTR_BITS (CTR_BITS),
    .PC_WIDTH (PC_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .FetchPc         (FetchPc),
    .PredTaken       (PredTaken),
    .PredNextPc      (PredNextPc),
    .UpdateValid     (UpdateValid),
    .UpdatePc        (UpdatePc),
    .UpdateTaken     (UpdateTaken),
    .UpdateTarget    (UpdateTarget),
    .UpdatePredTaken (UpdatePredTaken),
    .UpdatePredNextPc(UpdatePredNextPc),
    .Mispredict      (Mispredict),
    .Flush           (Flush),
    .MispredictCount (MispredictCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nVectors = 0;
  int nMiscompares = 0;

  // Behavioural BTB model, addressed by plain word arithmetic.
  bit          mValid  [ENTRIES];
  int unsigned mTag    [ENTRIES];
  int          mCtr    [ENTRIES];
  logic [31:0] mTarget [ENTRIES];
  int          mCount;

  function automatic int unsigned idxOf(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tagOf(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit modelHit(input logic [31:0] pc);
    return mValid[idxOf(pc)] && (mTag[idxOf(pc)] == tagOf(pc));
  endfunction

  function automatic bit modelTaken(input logic [31:0] pc);
    return modelHit(pc) && (mCtr[idxOf(pc)] >= CtrHalf);
  endfunction

  function automatic logic [31:0] modelNext(input logic [31:0] pc);
    return modelTaken(pc) ? mTarget[idxOf(pc)] : pc + 32'd4;
  endfunction

  function automatic bit modelMiss();
    logic [31:0] act;
    act = UpdateTaken ? UpdateTarget : UpdatePc + 32'd4;
    return UpdateValid && (UpdatePredNextPc != act);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mValid[i]  <= 1'b0;
        mTag[i]    <= 0;
        mCtr[i]    <= 0;
        mTarget[i] <= '0;
      end
      mCount <= 0;
    end else begin
      if (modelMiss()) mCount <= (mCount < CntMax) ? mCount + 1 : CntMax;
      if (Flush) begin
        for (int i = 0; i < ENTRIES; i++) mValid[i] <= 1'b0;
      end else if (UpdateValid) begin
        if (modelHit(UpdatePc)) begin
          if (UpdateTaken) begin
            mCtr[idxOf(UpdatePc)]    <= (mCtr[idxOf(UpdatePc)] < CtrMax) ?
                                        mCtr[idxOf(UpdatePc)] + 1 : CtrMax;
            mTarget[idxOf(UpdatePc)] <= UpdateTarget;
          end else begin
            mCtr[idxOf(UpdatePc)] <= (mCtr[idxOf(UpdatePc)] > 0) ?
                                     mCtr[idxOf(UpdatePc)] - 1 : 0;
          end
        end else if (UpdateTaken) begin
          mValid[idxOf(UpdatePc)]  <= 1'b1;
          mTag[idxOf(UpdatePc)]    <= tagOf(UpdatePc);
          mCtr[idxOf(UpdatePc)]    <= CtrHalf;
          mTarget[idxOf(UpdatePc)] <= UpdateTarget;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    check("predTaken", {31'b0, PredTaken}, {31'b0, modelTaken(FetchPc)});
    check("predNextPc", PredNextPc, modelNext(FetchPc));
    check("mispredict", {31'b0, Mispredict}, {31'b0, modelMiss()});
    check("mispredictCount", {24'b0, MispredictCount}, 32'(mCount));
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic atSample();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] fpc);
    FetchPc     = fpc;
    UpdateValid = 1'b0;
    Flush       = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic [31:0] predNext, input logic [31:0] fpc);
    FetchPc          = fpc;
    Flush            = 1'b0;
    UpdateValid      = 1'b1;
    UpdatePc         = pc;
    UpdateTaken      = taken;
    UpdateTarget     = tgt;
    UpdatePredNextPc = predNext;
    UpdatePredTaken  = (predNext != pc + 32'd4);
  endtask

  task automatic randomCycle();
    logic [31:0] pc, fpc, pn;
    if ($urandom_range(0, 7) == 0) pc = $urandom;
    else pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    fpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    case ($urandom_range(0, 3))
      0:       pn = pc + 32'd4;
      1:       pn = $urandom;
      default: pn = modelNext(pc);
    endcase
    upd(pc, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, pn, fpc);
    UpdateValid = ($urandom_range(0, 9) < 7);
    Flush       = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    reset = 1'b1;
    UpdatePc = '0;
    UpdateTaken = 1'b0;
    UpdateTarget = '0;
    UpdatePredTaken = 1'b0;
    UpdatePredNextPc = '0;
    idle(32'h40);
    atSample();
    check("resetPredTaken", {31'b0, PredTaken}, 32'd0);
    check("resetPredNextPc", PredNextPc, 32'h44);
    check("resetCount", {24'b0, MispredictCount}, 32'd0);
    nextCycle();
    reset = 1'b0;

    // First allocation, with a same-cycle lookup that must still see the old state.
    upd(32'h40, 1'b1, 32'h80, 32'h44, 32'h40);
    atSample();
    check("allocMispredict", {31'b0, Mispredict}, 32'd1);
    check("sameCycleOld", PredNextPc, 32'h44);
    nextCycle();
    idle(32'h40);
    atSample();
    check("allocPredTaken", {31'b0, PredTaken}, 32'd1);
    check("allocPredNextPc", PredNextPc, 32'h80);
    check("allocCount", {24'b0, MispredictCount}, 32'd1);

    // Counter training down to zero and past it.
    nextCycle(); upd(32'h40, 1'b0, 32'h80, 32'h80, 32'h40);
    nextCycle(); upd(32'h40, 1'b0, 32'h80, 32'h44, 32'h40);
    nextCycle(); idle(32'h40);
    atSample();
    check("trainedNotTaken", PredNextPc, 32'h44);
    nextCycle(); upd(32'h40, 1'b0, 32'h80, 32'h44, 32'h40);
    nextCycle(); upd(32'h40, 1'b1, 32'h80, 32'h44, 32'h40);
    nextCycle(); idle(32'h40);
    atSample();
    check("ctrFloorHeld", {31'b0, PredTaken}, 32'd0);

    // Three more taken saturate at 3; one not-taken must leave it predicting taken.
    for (int i = 0; i < 3; i++) begin
      nextCycle(); upd(32'h40, 1'b1, 32'h80, 32'h44, 32'h40);
    end
    nextCycle(); upd(32'h40, 1'b0, 32'h80, 32'h80, 32'h40);
    nextCycle(); idle(32'h40);
    atSample();
    check("ctrCeilingHeld", {31'b0, PredTaken}, 32'd1);

    // Alias eviction on index 0.
    nextCycle(); upd(32'h80, 1'b1, 32'h200, 32'h84, 32'h40);
    nextCycle(); idle(32'h40);
    atSample();
    check("aliasEvicted", PredNextPc, 32'h44);
    nextCycle(); idle(32'h80);
    atSample();
    check("aliasNewTarget", PredNextPc, 32'h200);

    // Flush beats a simultaneous taken update.
    nextCycle(); upd(32'h100, 1'b1, 32'h180, 32'h104, 32'h100);
    nextCycle(); upd(32'h40, 1'b1, 32'h300, 32'h44, 32'h40); Flush = 1'b1;
    atSample();
    check("flushMispredict", {31'b0, Mispredict}, 32'd1);
    nextCycle(); idle(32'h40);
    atSample();
    check("flushMiss40", PredNextPc, 32'h44);
    nextCycle(); idle(32'h100);
    atSample();
    check("flushMiss100", PredNextPc, 32'h104);
    nextCycle(); idle(32'hFFFF_FFFC);
    atSample();
    check("pcWrap", PredNextPc, 32'h0);

    for (int i = 0; i < 2000; i++) begin
      nextCycle();
      randomCycle();
    end

    // Drive the statistics counter past its ceiling.
    for (int i = 0; i < (1 << CNT_WIDTH) + 3; i++) begin
      nextCycle(); upd(32'h40, 1'b1, 32'h80, 32'h44, 32'h40);
    end
    nextCycle(); idle(32'h40);
    atSample();
    check("countSaturated", {24'b0, MispredictCount}, 32'hFF);
    check("preResetTaken", {31'b0, PredTaken}, 32'd1);

    // Asynchronous reset away from any clock edge.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("asyncResetTaken", {31'b0, PredTaken}, 32'd0);
    check("asyncResetNextPc", PredNextPc, 32'h44);
    check("asyncResetCount", {24'b0, MispredictCount}, 32'd0);
    nextCycle();
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      nextCycle();
      randomCycle();
    end
    nextCycle();
    idle(32'h40);
    atSample();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
